// File: rtl/mem_stage.sv
// Memory-access stage: passes non-memory results through, runs one bus
// transaction per load/store with big-endian lane steering and a timeout.
`timescale 1ns/1ps

// state  | meaning
// S_IDLE | pass-through, or launch an aligned load/store
// S_BUS  | dbus_req held high, waiting for dbus_ack or timeout
// S_DONE | one-cycle result presentation to mem_wb, pipeline released
module mem_stage #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ex_wd,
  input  logic        ex_wreg,
  input  logic [31:0] ex_wdata,
  input  logic [3:0]  ex_memop,
  input  logic [31:0] ex_memaddr,
  output logic [4:0]  mem_wd,
  output logic        mem_wreg,
  output logic [31:0] mem_wdata,
  output logic        stallreq,
  output logic        exc_align,
  output logic        bus_err,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_sel,
  output logic [31:0] dbus_wdata,
  input  logic [31:0] dbus_rdata,
  input  logic        dbus_ack
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [4:0]       wd_r;
  logic [3:0]       op_r;
  logic [1:0]       lo_r;
  logic [31:0]      result_r;
  logic             err_r;

  logic        is_byte, is_half, is_word, is_st, is_mem, misalign;
  logic [3:0]  sel_n;
  logic [31:0] wdata_n;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_val;
  logic        is_ld_r;

  // Decode of the incoming EX/MEM op; only consulted in S_IDLE.
  always_comb begin
    is_byte = 1'b0;
    is_half = 1'b0;
    is_word = 1'b0;
    is_st   = 1'b0;
    case (ex_memop)
      OP_LB, OP_LBU: is_byte = 1'b1;
      OP_LH, OP_LHU: is_half = 1'b1;
      OP_LW:         is_word = 1'b1;
      OP_SB:         begin is_byte = 1'b1; is_st = 1'b1; end
      OP_SH:         begin is_half = 1'b1; is_st = 1'b1; end
      OP_SW:         begin is_word = 1'b1; is_st = 1'b1; end
      default:       ;
    endcase
    is_mem   = is_byte | is_half | is_word;
    misalign = (is_half & ex_memaddr[0]) | (is_word & (ex_memaddr[1:0] != 2'b00));
    sel_n    = 4'b1111;
    wdata_n  = ex_wdata;
    if (is_byte) begin
      sel_n   = 4'b1000 >> ex_memaddr[1:0];
      wdata_n = {4{ex_wdata[7:0]}};
    end else if (is_half) begin
      sel_n   = ex_memaddr[1] ? 4'b0011 : 4'b1100;
      wdata_n = {2{ex_wdata[15:0]}};
    end
  end

  // Big-endian: the lowest byte address lives in bits 31:24.
  always_comb begin
    case (lo_r)
      2'd0:    ld_byte = dbus_rdata[31:24];
      2'd1:    ld_byte = dbus_rdata[23:16];
      2'd2:    ld_byte = dbus_rdata[15:8];
      default: ld_byte = dbus_rdata[7:0];
    endcase
    ld_half = lo_r[1] ? dbus_rdata[15:0] : dbus_rdata[31:16];
    case (op_r)
      OP_LB:   ld_val = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  ld_val = {24'd0, ld_byte};
      OP_LH:   ld_val = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  ld_val = {16'd0, ld_half};
      default: ld_val = dbus_rdata;
    endcase
    is_ld_r = (op_r >= OP_LB) && (op_r <= OP_LW);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      wd_r       <= '0;
      op_r       <= '0;
      lo_r       <= '0;
      result_r   <= '0;
      err_r      <= 1'b0;
      dbus_req   <= 1'b0;
      dbus_we    <= 1'b0;
      dbus_addr  <= '0;
      dbus_sel   <= '0;
      dbus_wdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (is_mem && !misalign) begin
            wd_r       <= ex_wd;
            op_r       <= ex_memop;
            lo_r       <= ex_memaddr[1:0];
            err_r      <= 1'b0;
            cnt        <= '0;
            dbus_req   <= 1'b1;
            dbus_we    <= is_st;
            dbus_addr  <= {ex_memaddr[31:2], 2'b00};
            dbus_sel   <= sel_n;
            dbus_wdata <= is_st ? wdata_n : 32'd0;
            state      <= S_BUS;
          end
        end
        S_BUS: begin
          cnt <= cnt + CNT_W'(1);
          // An ack coinciding with the last allowed cycle still completes.
          if (dbus_ack) begin
            result_r <= ld_val;
            dbus_req <= 1'b0;
            state    <= S_DONE;
          end else if (cnt == CNT_LAST) begin
            err_r    <= 1'b1;
            dbus_req <= 1'b0;
            state    <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_wd    = 5'd0;
    mem_wreg  = 1'b0;
    mem_wdata = 32'd0;
    stallreq  = 1'b0;
    exc_align = 1'b0;
    bus_err   = 1'b0;
    if (!rst) begin
      case (state)
        S_IDLE: begin
          if (!is_mem) begin
            mem_wd    = ex_wd;
            mem_wreg  = ex_wreg;
            mem_wdata = ex_wdata;
          end else if (misalign) begin
            exc_align = 1'b1;
          end else begin
            stallreq = 1'b1;
          end
        end
        S_BUS: stallreq = 1'b1;
        S_DONE: begin
          mem_wd    = wd_r;
          mem_wreg  = is_ld_r & ~err_r;
          mem_wdata = (is_ld_r & ~err_r) ? result_r : 32'd0;
          bus_err   = err_r;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table plus a DONE-cycle scoreboard.
`timescale 1ns/1ps

module tb_mem_stage;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata;
  logic [3:0]  ex_memop;
  logic [31:0] ex_memaddr;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic        stallreq, exc_align, bus_err;
  logic        dbus_req, dbus_we;
  logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
  logic [3:0]  dbus_sel;
  logic        dbus_ack;

  mem_stage #(.TIMEOUT(TO), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
    .ex_memop(ex_memop), .ex_memaddr(ex_memaddr),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .stallreq(stallreq), .exc_align(exc_align), .bus_err(bus_err),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_sel(dbus_sel), .dbus_wdata(dbus_wdata),
    .dbus_rdata(dbus_rdata), .dbus_ack(dbus_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] rdata;
    int          ack_at;   // BUS cycle index carrying the ack, -1 = never
    logic [3:0]  e_sel;
    logic        e_we;
    logic [31:0] e_dwdata;
    logic        e_align;
    logic        e_wreg;
    logic [31:0] e_mwdata;
    logic        e_err;
  } vec_t;

  typedef struct {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        err;
    int          nreq;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   passed = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Scoreboard: the DONE cycle is the first non-reset cycle after dbus_req falls.
  logic prev_req = 1'b0;
  int   req_cycles = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_req   = 1'b0;
      req_cycles = 0;
    end else begin
      if (dbus_req) req_cycles++;
      else if (prev_req) begin
        if (q.size() == 0) chk("sb_unexpected_done", 32'd1, 32'd0);
        else begin
          e = q.pop_front();
          chk("done_wd",    {27'd0, mem_wd},   {27'd0, e.wd});
          chk("done_wreg",  {31'd0, mem_wreg}, {31'd0, e.wreg});
          chk("done_wdata", mem_wdata,         e.wdata);
          chk("done_buserr",{31'd0, bus_err},  {31'd0, e.err});
          chk("done_stall", {31'd0, stallreq}, 32'd0);
          chk("req_cycles", req_cycles,        e.nreq);
        end
        req_cycles = 0;
      end
      prev_req = dbus_req;
    end
  end

  vec_t vecs[15];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v;
    exp_t e;
    int nbus;
    bit is_none;

    vecs[0]  = '{4'd0,  32'h0,   32'h1234,     5'd3,  1'b1, 32'h0,        -1, 4'b0000, 1'b0, 32'h0,        1'b0, 1'b1, 32'h1234,     1'b0};
    vecs[1]  = '{4'd1,  32'h101, 32'h0,        5'd5,  1'b1, 32'h11F23344,  2, 4'b0100, 1'b0, 32'h0,        1'b0, 1'b1, 32'hFFFFFFF2, 1'b0};
    vecs[2]  = '{4'd2,  32'h101, 32'h0,        5'd6,  1'b1, 32'h11F23344,  2, 4'b0100, 1'b0, 32'h0,        1'b0, 1'b1, 32'h000000F2, 1'b0};
    vecs[3]  = '{4'd7,  32'h202, 32'hABCD5678, 5'd0,  1'b0, 32'h0,         0, 4'b0011, 1'b1, 32'h56785678, 1'b0, 1'b0, 32'h0,        1'b0};
    vecs[4]  = '{4'd5,  32'h3,   32'h0,        5'd7,  1'b1, 32'h0,        -1, 4'b0000, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0};
    vecs[5]  = '{4'd5,  32'h400, 32'h0,        5'd8,  1'b1, 32'h0,        -1, 4'b1111, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1};
    vecs[6]  = '{4'd3,  32'h10,  32'h0,        5'd9,  1'b1, 32'h80017FFF,  1, 4'b1100, 1'b0, 32'h0,        1'b0, 1'b1, 32'hFFFF8001, 1'b0};
    vecs[7]  = '{4'd4,  32'h12,  32'h0,        5'd10, 1'b1, 32'h80017FFF,  1, 4'b0011, 1'b0, 32'h0,        1'b0, 1'b1, 32'h00007FFF, 1'b0};
    vecs[8]  = '{4'd6,  32'h7,   32'h000000A5, 5'd11, 1'b0, 32'h0,         0, 4'b0001, 1'b1, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h0,        1'b0};
    vecs[9]  = '{4'd8,  32'h8,   32'hDEADBEEF, 5'd12, 1'b0, 32'h0,         1, 4'b1111, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0,        1'b0};
    vecs[10] = '{4'd1,  32'h3,   32'h0,        5'd13, 1'b1, 32'h0000007F,  0, 4'b0001, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0000007F, 1'b0};
    vecs[11] = '{4'd7,  32'h1,   32'h0,        5'd14, 1'b1, 32'h0,        -1, 4'b0000, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0};
    vecs[12] = '{4'd12, 32'h44,  32'h55,       5'd15, 1'b1, 32'h0,        -1, 4'b0000, 1'b0, 32'h0,        1'b0, 1'b1, 32'h55,       1'b0};
    vecs[13] = '{4'd5,  32'h20,  32'h0,        5'd16, 1'b1, 32'hCAFEF00D,  3, 4'b1111, 1'b0, 32'h0,        1'b0, 1'b1, 32'hCAFEF00D, 1'b0};
    vecs[14] = '{4'd2,  32'h2,   32'h0,        5'd17, 1'b1, 32'h0000AB00,  0, 4'b0010, 1'b0, 32'h0,        1'b0, 1'b1, 32'h000000AB, 1'b0};

    // Reset held two cycles with a load presented.
    rst = 1'b1; ex_memop = 4'd5; ex_wd = 5'd9; ex_wreg = 1'b1; ex_wdata = 32'h77;
    ex_memaddr = 32'h0; dbus_ack = 1'b0; dbus_rdata = 32'h0;
    @(posedge clk); @(negedge clk);
    chk("rst_req",   {31'd0, dbus_req},  32'd0);
    chk("rst_wreg",  {31'd0, mem_wreg},  32'd0);
    chk("rst_wd",    {27'd0, mem_wd},    32'd0);
    chk("rst_stall", {31'd0, stallreq},  32'd0);
    chk("rst_sel",   {28'd0, dbus_sel},  32'd0);
    @(posedge clk);

    for (int i = 0; i < 15; i++) begin
      v = vecs[i];
      #1;
      rst = 1'b0; dbus_ack = 1'b0;
      ex_memop = v.op; ex_memaddr = v.addr; ex_wdata = v.wdata; ex_wd = v.wd; ex_wreg = v.wreg;
      dbus_rdata = v.rdata;
      is_none = (v.op == 4'd0) || (v.op > 4'd8);
      @(negedge clk);
      if (is_none) begin
        chk($sformatf("v%0d_pt_wd", i),    {27'd0, mem_wd},    {27'd0, v.wd});
        chk($sformatf("v%0d_pt_wreg", i),  {31'd0, mem_wreg},  {31'd0, v.e_wreg});
        chk($sformatf("v%0d_pt_wdata", i), mem_wdata,          v.e_mwdata);
        chk($sformatf("v%0d_pt_stall", i), {31'd0, stallreq},  32'd0);
        chk($sformatf("v%0d_pt_req", i),   {31'd0, dbus_req},  32'd0);
        @(posedge clk);
      end else if (v.e_align) begin
        chk($sformatf("v%0d_al_exc", i),   {31'd0, exc_align}, 32'd1);
        chk($sformatf("v%0d_al_wreg", i),  {31'd0, mem_wreg},  32'd0);
        chk($sformatf("v%0d_al_stall", i), {31'd0, stallreq},  32'd0);
        @(posedge clk); @(negedge clk);
        chk($sformatf("v%0d_al_req", i),   {31'd0, dbus_req},  32'd0);
        chk($sformatf("v%0d_al_exc2", i),  {31'd0, exc_align}, 32'd1);
        @(posedge clk);
      end else begin
        chk($sformatf("v%0d_id_stall", i), {31'd0, stallreq},  32'd1);
        chk($sformatf("v%0d_id_wreg", i),  {31'd0, mem_wreg},  32'd0);
        chk($sformatf("v%0d_id_req", i),   {31'd0, dbus_req},  32'd0);
        nbus = (v.ack_at >= 0) ? v.ack_at + 1 : TO;
        e.wd = v.wd; e.wreg = v.e_wreg; e.wdata = v.e_mwdata; e.err = v.e_err; e.nreq = nbus;
        q.push_back(e);
        @(posedge clk);
        for (int c = 0; c <= nbus; c++) begin
          #1;
          dbus_ack = (c == v.ack_at);
          ex_memop = 4'd5; ex_wd = 5'd31; ex_memaddr = $urandom; ex_wdata = $urandom;
          @(negedge clk);
          if (c < nbus) begin
            chk($sformatf("v%0d_b%0d_req", i, c),   {31'd0, dbus_req}, 32'd1);
            chk($sformatf("v%0d_b%0d_stall", i, c), {31'd0, stallreq}, 32'd1);
            chk($sformatf("v%0d_b%0d_sel", i, c),   {28'd0, dbus_sel}, {28'd0, v.e_sel});
            chk($sformatf("v%0d_b%0d_addr", i, c),  dbus_addr,         {v.addr[31:2], 2'b00});
            chk($sformatf("v%0d_b%0d_we", i, c),    {31'd0, dbus_we},  {31'd0, v.e_we});
            if (v.e_we) chk($sformatf("v%0d_b%0d_wdata", i, c), dbus_wdata, v.e_dwdata);
          end
          @(posedge clk);
        end
        chk($sformatf("v%0d_sb_drained", i), q.size(), 32'd0);
        q.delete();
      end
    end

    // Reset during the second BUS cycle abandons the transaction.
    #1;
    dbus_ack = 1'b0; ex_memop = 4'd5; ex_memaddr = 32'h40; ex_wd = 5'd2; ex_wreg = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("mid_req_before", {31'd0, dbus_req}, 32'd1);
    chk("mid_rst_stall",  {31'd0, stallreq}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0; ex_memop = 4'd0; ex_wd = 5'd4; ex_wreg = 1'b1; ex_wdata = 32'h99;
    dbus_ack = 1'b1; dbus_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    chk("mid_req_after", {31'd0, dbus_req}, 32'd0);
    chk("mid_stall",     {31'd0, stallreq}, 32'd0);
    chk("mid_wd",        {27'd0, mem_wd},   32'd4);
    chk("mid_wdata",     mem_wdata,         32'h99);
    chk("mid_buserr",    {31'd0, bus_err},  32'd0);
    @(posedge clk);
    #1 dbus_ack = 1'b0;
    @(negedge clk);
    chk("late_req",    {31'd0, dbus_req}, 32'd0);
    chk("late_wdata",  mem_wdata,         32'h99);
    chk("late_wreg",   {31'd0, mem_wreg}, 32'd1);
    chk("late_buserr", {31'd0, bus_err},  32'd0);
    chk("late_sb",     q.size(),          32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage pipeline. Sits between the EX/MEM register and mem_wb.
- Non-memory instructions pass straight through to mem_wb.
- Loads and stores run a data-bus request/acknowledge transaction. The stage holds the pipeline with stallreq until the transaction completes.
- Performs big-endian byte-lane steering, sign/zero extension, alignment checking and bus timeout.

Parameters:
- TIMEOUT, 16, number of BUS-state cycles without mem_ack before the transaction is aborted (minimum 2).
- CNT_W, 5, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  synchronous, active-high reset (RstEnable = 1).
- ex_wd  in  5  destination register address.
- ex_wreg  in  1  register write enable.
- ex_wdata  in  32  ALU result (non-memory ops) or store data (stores).
- ex_memop  in  4  0=none, 1=LB, 2=LBU, 3=LH, 4=LHU, 5=LW, 6=SB, 7=SH, 8=SW; 9-15 are treated as none.
- ex_memaddr  in  32  effective byte address.
- mem_wd  out  5  to mem_wb.
- mem_wreg  out  1  to mem_wb.
- mem_wdata  out  32  to mem_wb.
- stallreq  out  1  pipeline stall request to the controller.
- exc_align  out  1  misaligned-access pulse.
- bus_err  out  1  timeout pulse.
- dbus_req  out  1  bus request, registered.
- dbus_we  out  1  1 = write, registered.
- dbus_addr  out  32  word address, {addr[31:2], 2'b00}, registered.
- dbus_sel  out  4  byte enables, bit 3 = bits 31:24, registered.
- dbus_wdata  out  32  write data, registered.
- dbus_rdata  in  32  read data, valid when dbus_ack = 1.
- dbus_ack  in  1  one-cycle completion.

Behaviour:
- Reset (synchronous, rst = 1 at a rising edge):
  - State goes to IDLE and the counter clears.
  - dbus_req, dbus_we, dbus_addr, dbus_sel and dbus_wdata go to 0.
  - mem_wd = NOPRegAddr (0), mem_wreg = WriteDisable (0), mem_wdata = ZeroWord.
  - stallreq, exc_align and bus_err are 0 while rst = 1.
  - Reset in the BUS state abandons the transaction; dbus_req is 0 after that edge. A late dbus_ack is ignored.
- States: IDLE, BUS, DONE.
- IDLE, ex_memop = none:
  - mem_wd/mem_wreg/mem_wdata = ex_wd/ex_wreg/ex_wdata, combinational, zero latency.
  - stallreq = 0.
- IDLE, misaligned op:
  - Misaligned means LH/LHU/SH with addr[0] = 1, or LW/SW with addr[1:0] != 0.
  - No bus cycle is issued.
  - exc_align = 1 and mem_wreg = 0, combinational.
  - stallreq = 0; stay in IDLE.
- IDLE, aligned memory op:
  - stallreq = 1, combinational; mem_wreg = 0.
  - At the next edge: latch wd, op and addr[1:0]; drive dbus_* registers; go to BUS; counter = 0.
- Lane mapping (big-endian):
  - Byte: addr 0 → sel 1000, data bits 31:24; addr 1 → 0100 / 23:16; addr 2 → 0010 / 15:8; addr 3 → 0001 / 7:0.
  - Half: addr 0 → sel 1100, bits 31:16; addr 2 → sel 0011, bits 15:0.
  - Word: sel 1111.
  - Store data is replicated into the selected lanes (e.g. SB byte on all four lanes).
- BUS:
  - dbus_req = 1; stallreq = 1; mem_wreg = 0.
  - Counter increments each cycle.
  - If dbus_ack = 1: capture the extended load data (LB/LH sign-extend, LBU/LHU zero-extend) into result_r, drop dbus_req, go to DONE.
  - Else if counter == TIMEOUT-1: drop dbus_req, set err_r, go to DONE.
  - If ack arrives in the same cycle as the timeout limit, ack wins.
- DONE (exactly one cycle):
  - stallreq = 0.
  - mem_wd = latched wd.
  - mem_wreg = 1 only for a load without error.
  - mem_wdata = result_r for loads, ZeroWord for stores or errors.
  - bus_err = err_r.
  - Next state IDLE. The pipeline advances at the end of this cycle.
- Back-to-back memory ops: IDLE follows DONE, so there is one idle/bubble cycle minimum between consecutive bus requests.
- ex_* inputs are ignored in the BUS and DONE states; only latched values are used.

Test Plan:
- Reset: rst = 1 for 2 cycles with ex_memop = 5 → dbus_req = 0, mem_wreg = 0, mem_wd = 0, stallreq = 0.
- Pass-through: ex_memop = 0, ex_wd = 3, ex_wreg = 1, ex_wdata = 0x1234 → same cycle mem_wd = 3, mem_wreg = 1, mem_wdata = 0x1234, stallreq = 0.
- LB sign extension: addr = 0x101, ack after 3 BUS cycles with rdata = 0x11F23344 →
  - dbus_sel = 0100 and dbus_addr = 0x100 throughout BUS;
  - stallreq high for 4 cycles;
  - DONE mem_wdata = 0xFFFFFFF2.
  - Repeat as LBU → 0x000000F2.
- SH: addr = 0x202, ex_wdata = 0xABCD5678, ack on the first BUS cycle → dbus_we = 1, sel = 0011, wdata = 0x56785678; DONE mem_wreg = 0.
- Misaligned LW at addr 0x3 → exc_align = 1, no dbus_req, mem_wreg = 0, stallreq = 0.
- Timeout: LW with TIMEOUT = 4 and no ack → dbus_req high for exactly 4 cycles, then DONE with bus_err = 1 and mem_wreg = 0.
- Reset mid-BUS: rst on the 2nd BUS cycle → dbus_req = 0 after that edge; ack on the following cycle causes no output change.
